min_index_tracker: RTL and testbench

- Parameterised running-extremum tracker for the chain multiplier datapath. Successor to the fixed 32-bit minimum/k register pair.
- Accepts a frame of unsigned samples on a valid/last stream and tracks the extremum (min or max, selected per frame) and its index k.
- Reports the extremum, k and the sample count with a one-cycle done pulse.
- Per-frame start, frame-length overflow detection and deterministic tie-breaking are added.

---
 rtl/min_index_tracker_pkg.sv | 10 +
 rtl/min_index_tracker_if.sv | 26 ++
 rtl/min_index_tracker_mag_cmp.sv | 15 +
 rtl/min_index_tracker.sv | 83 ++++++++
 tb/tb_min_index_tracker.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/min_index_tracker_pkg.sv
// min_index_tracker_pkg: shared FSM state encoding, mode constants and init-value helper
package min_index_tracker_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;
  // Fill bit of the tracker init value: all ones for min tracking, zero for max.
  function automatic logic init_fill(input logic mode);
    return mode == MODE_MIN;
  endfunction
endpackage

// File: rtl/min_index_tracker_if.sv
// min_index_tracker_if: sample stream in, extremum/index/status out
// master drives start/mode_max/in_* and observes results; slave is the tracker.
interface min_index_tracker_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
);
  logic              start;
  logic              mode_max;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic [DATA_W-1:0] ext_out;
  logic [IDX_W-1:0]  k_out;
  logic [IDX_W:0]    count_out;
  logic              busy;
  logic              done;
  logic              overflow;
  modport master (
    output start, mode_max, in_valid, in_data, in_last,
    input  ext_out, k_out, count_out, busy, done, overflow
  );
  modport slave (
    input  start, mode_max, in_valid, in_data, in_last,
    output ext_out, k_out, count_out, busy, done, overflow
  );
endinterface

// File: rtl/min_index_tracker_mag_cmp.sv
// mag_cmp: unsigned DATA_W magnitude comparator
// i_a/i_b operands; o_lt/o_gt/o_eq compare i_a against i_b.
module mag_cmp #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_lt,
  output logic              o_gt,
  output logic              o_eq
);
  assign o_lt = i_a < i_b;
  assign o_gt = i_a > i_b;
  assign o_eq = i_a == i_b;
endmodule

// File: rtl/min_index_tracker.sv
// min_index_tracker: running min/max tracker with index, count, done pulse and overflow flag
// clk/rst: clock and async active-high reset; bus: slave side of min_index_tracker_if.
module min_index_tracker
  import min_index_tracker_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input logic                 clk,
  input logic                 rst,
  min_index_tracker_if.slave  bus
);
  state_t            r_state;
  logic              r_mode;
  logic [DATA_W-1:0] r_ext;
  logic [IDX_W-1:0]  r_k;
  logic [IDX_W:0]    r_count;
  logic              r_done;
  logic              r_ovf;
  logic              w_lt, w_gt, w_eq;
  logic              w_full;
  logic              w_upd;
  mag_cmp #(.DATA_W(DATA_W)) u_cmp (
    .i_a  (bus.in_data),
    .i_b  (r_ext),
    .o_lt (w_lt),
    .o_gt (w_gt),
    .o_eq (w_eq)
  );
  // count only reaches 2^IDX_W, so its top bit alone marks a full frame
  assign w_full = r_count[IDX_W];
  // strict comparison: ties keep the earlier index
  assign w_upd  = !w_eq && (r_mode == MODE_MAX ? w_gt : w_lt);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_MIN;
      r_ext   <= {DATA_W{init_fill(MODE_MIN)}};
      r_k     <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.start) begin
        r_state <= ST_RUN;
        r_mode  <= bus.mode_max;
        r_ext   <= {DATA_W{init_fill(bus.mode_max)}};
        r_k     <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else begin
        unique case (r_state)
          ST_RUN: begin
            if (bus.in_valid) begin
              if (w_full) begin
                r_ovf <= 1'b1;
              end else begin
                r_count <= r_count + 1'b1;
                if (w_upd) begin
                  r_ext <= bus.in_data;
                  r_k   <= r_count[IDX_W-1:0];
                end
              end
              if (bus.in_last) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end
  assign bus.ext_out   = r_ext;
  assign bus.k_out     = r_k;
  assign bus.count_out = r_count;
  assign bus.busy      = r_state == ST_RUN;
  assign bus.done      = r_done;
  assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_min_index_tracker.sv
// tb_min_index_tracker: directed self-checking bench; a second IDX_W=2 instance shares the stimulus for overflow
module tb_min_index_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   dcnt   = 0;
  always #5 clk = ~clk;
  min_index_tracker_if #(.DATA_W(32), .IDX_W(8)) b  ();
  min_index_tracker_if #(.DATA_W(32), .IDX_W(2)) b2 ();
  assign b2.start    = b.start;
  assign b2.mode_max = b.mode_max;
  assign b2.in_valid = b.in_valid;
  assign b2.in_data  = b.in_data;
  assign b2.in_last  = b.in_last;
  min_index_tracker #(.DATA_W(32), .IDX_W(8)) u_dut (.clk(clk), .rst(rst), .bus(b));
  min_index_tracker #(.DATA_W(32), .IDX_W(2)) u_ovf (.clk(clk), .rst(rst), .bus(b2));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    if (b.done) dcnt++;
  endtask
  task automatic start_frame(input logic mode);
    b.start    = 1'b1;
    b.mode_max = mode;
    step();
    b.start    = 1'b0;
    b.mode_max = ~mode;
  endtask
  task automatic send(input logic [31:0] d, input logic last);
    b.in_valid = 1'b1;
    b.in_data  = d;
    b.in_last  = last;
    step();
    b.in_valid = 1'b0;
    b.in_last  = 1'b0;
  endtask
  initial begin
    b.start = 0; b.mode_max = 0; b.in_valid = 0; b.in_data = 0; b.in_last = 0;
    #12;
    chk("rst_ext", b.ext_out, 32'hFFFF_FFFF);
    chk("rst_k", b.k_out, 0);
    chk("rst_cnt", b.count_out, 0);
    chk("rst_busy", b.busy, 0);
    chk("rst_done", b.done, 0);
    chk("rst_ovf", b.overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    // in_valid in IDLE is ignored
    send(32'd3, 1'b1);
    chk("idle_cnt", b.count_out, 0);
    chk("idle_done", b.done, 0);
    // min mode with a tie
    start_frame(1'b0);
    chk("t1_busy", b.busy, 1);
    chk("t1_init", b.ext_out, 32'hFFFF_FFFF);
    send(32'd40, 0); send(32'd17, 0); send(32'd99, 0); send(32'd17, 0);
    chk("t1_tie_ext", b.ext_out, 17);
    chk("t1_tie_k", b.k_out, 1);
    send(32'd5, 1);
    chk("t1_done", b.done, 1);
    chk("t1_ext", b.ext_out, 5);
    chk("t1_k", b.k_out, 4);
    chk("t1_cnt", b.count_out, 5);
    step();
    chk("t1_done_low", b.done, 0);
    chk("t1_idle", b.busy, 0);
    chk("t1_hold", b.ext_out, 5);
    // max mode, gapped valid
    dcnt = 0;
    start_frame(1'b1);
    chk("t2_init", b.ext_out, 0);
    send(32'd3, 0); step(); send(32'd250, 0); step(); send(32'd250, 0); send(32'd7, 1);
    step(); step();
    chk("t2_ext", b.ext_out, 250);
    chk("t2_k", b.k_out, 1);
    chk("t2_cnt", b.count_out, 4);
    chk("t2_dcnt", dcnt, 1);
    // async reset mid-frame
    start_frame(1'b1);
    send(32'd1, 0); send(32'd2, 0);
    #2 rst = 1'b1;
    #1;
    chk("t3_ext", b.ext_out, 32'hFFFF_FFFF);
    chk("t3_k", b.k_out, 0);
    chk("t3_busy", b.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    send(32'd4, 0);
    chk("t3_cnt", b.count_out, 0);
    chk("t3_ext2", b.ext_out, 32'hFFFF_FFFF);
    // restart mid-frame, start beats a same-cycle last
    start_frame(1'b0);
    send(32'd5, 0); send(32'd6, 0); send(32'd7, 0);
    dcnt = 0;
    b.in_valid = 1'b1; b.in_data = 32'd1; b.in_last = 1'b1;
    start_frame(1'b0);
    b.in_valid = 1'b0; b.in_last = 1'b0;
    chk("t4_restart_cnt", b.count_out, 0);
    chk("t4_restart_busy", b.busy, 1);
    send(32'd9, 0); send(32'd2, 1);
    chk("t4_done", b.done, 1);
    chk("t4_ext", b.ext_out, 2);
    chk("t4_k", b.k_out, 1);
    chk("t4_cnt", b.count_out, 2);
    chk("t4_dcnt", dcnt, 1);
    // overflow on the IDX_W=2 instance
    start_frame(1'b0);
    send(32'd8, 0); send(32'd6, 0); send(32'd4, 0); send(32'd2, 0);
    chk("t5_pre_ovf", b2.overflow, 0);
    send(32'd1, 1);
    chk("t5_ext", b2.ext_out, 2);
    chk("t5_k", b2.k_out, 3);
    chk("t5_cnt", b2.count_out, 4);
    chk("t5_ovf", b2.overflow, 1);
    chk("t5_done", b2.done, 1);
    chk("t5_wide_ext", b.ext_out, 1);
    chk("t5_wide_ovf", b.overflow, 0);
    step();
    chk("t5_ovf_sticky", b2.overflow, 1);
    // init-value edge, also clears overflow
    start_frame(1'b0);
    chk("t6_ovf_clr", b2.overflow, 0);
    send(32'hFFFF_FFFF, 1);
    chk("t6_done", b.done, 1);
    chk("t6_ext", b.ext_out, 32'hFFFF_FFFF);
    chk("t6_k", b.k_out, 0);
    chk("t6_cnt", b.count_out, 1);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
